cosim_core_sequencer: RTL
=========================

// Module: cosim_core_sequencer
// PURPOSE
// - Synthesizable, parametrised core run sequencer for the cosim testbench top.
// - Runs the cores one at a time, in ascending index order, for every bit set in a core mask.
// - Drives per-core tile reset and core reset requests, which the top ORs into the CPU resets.
// - Waits for each core's pass/fail indication, with a programmable timeout, and records per-core results.
// PARAMETERS
// - NUM_CORES     4   number of sequenced cores (1..16)
// - TIMEOUT_W     32  width of the timeout limit and cycle counter
// - RESET_CYCLES  2   all-core reset pulse length, virtual mode only (>=1)
// PORTS
// - clk             in   1            system clock
// - rst             in   1            synchronous, active-high reset
// - start           in   1            1-cycle request; sampled only in IDLE
// - abort           in   1            return to IDLE and release all resets
// - core_mask       in   NUM_CORES    cores to run; sampled at start
// - timeout_limit   in   TIMEOUT_W    max RUN cycles per core; 0 disables; sampled at start
// - program_loaded  in   1            level: program image is in main memory
// - core_pass       in   NUM_CORES    per-core pass status (level)
// - core_fail       in   NUM_CORES    per-core fail status (level)
// - virtual_mode    in   1            present only with CORE_SEQ_VIRTUAL_MODE_EN
// - tile_reset_o    out  NUM_CORES    tile/cache reset request
// - core_reset_o    out  NUM_CORES    core-only reset request
// - cur_core_o      out  clog2(N)     index of the core in RUN
// - busy_o          out  1            FSM not in IDLE
// - done_o          out  1            1-cycle pulse when the sequence completes
// - pass_mask_o     out  NUM_CORES    cores that passed
// - fail_mask_o     out  NUM_CORES    cores that failed or timed out
// - tmo_mask_o      out  NUM_CORES    cores that timed out
// BEHAVIOUR
// - All outputs are registered. Reset value of every output is 0.
// - States: IDLE, WAIT_LOAD, SELECT, ALLRST, RUN, NEXT, DONE.
// - IDLE: on start, latch core_mask and timeout_limit and clear the result masks.
//   - Next cycle: WAIT_LOAD, with tile_reset_o and core_reset_o all 1.
// - WAIT_LOAD: waits for program_loaded to be high (level).
//   - If program_loaded is already high at start, exit after exactly 1 cycle.
//   - On exit, tile_reset_o drops to 0; core_reset_o stays all 1.
// - SELECT: find the lowest set mask bit at index >= the scan pointer.
//   - If found, go to RUN, or to ALLRST when virtual mode is active. Drive cur_core_o.
//   - If none is found, go to DONE.
// - RUN: core_reset_o[cur] = 0 from the first RUN cycle.
//   - The cycle counter starts at 0 and increments every RUN cycle.
//   - pass/fail edges are detected against registered previous values. A rising edge of
//     core_pass[cur] or core_fail[cur] ends RUN.
//   - Fail edge: set fail_mask_o[cur]. Pass edge: set pass_mask_o[cur].
//   - Pass and fail rising in the same cycle: fail wins.
//   - A pass/fail level already high on entry is not an edge.
//   - Other cores' pass/fail inputs are ignored.
//   - Timeout: timeout_limit != 0 and counter == timeout_limit - 1 with no edge that cycle
//     sets tmo_mask_o[cur] and fail_mask_o[cur]. An edge in the same cycle takes precedence.
// - NEXT: core_reset_o[cur] returns to 1, so a finished core is parked. Scan pointer = cur+1.
//   Next state is SELECT. When cur = NUM_CORES-1, there is no wrap: next state is DONE.
// - DONE: done_o = 1 for one cycle, then IDLE.
//   - tile_reset_o, core_reset_o and the result masks hold their values until the next start, abort or rst.
// - Latency example: start at cycle 0, program_loaded high, mask = 4'b0001.
//   - cycle 1: WAIT_LOAD. cycle 2: SELECT, tile resets 0. cycle 3: RUN, core_reset_o[0] = 0.
// - core_mask = 0: after the load, SELECT goes straight to DONE, with zero results.
// - start while busy_o is high is ignored.
// - abort has priority over all other events. Next cycle: IDLE, tile_reset_o = 0,
//   core_reset_o = 0, results hold, no done_o pulse.
// - rst in any state: the FSM returns to IDLE and every output clears on the next edge.
// CONFIGURATION
// - CORE_SEQ_VIRTUAL_MODE_EN defined: the virtual_mode port exists.
//   - If virtual_mode is sampled 1 at start, SELECT goes to ALLRST before each RUN.
//   - ALLRST drives tile_reset_o all 1 for exactly RESET_CYCLES cycles, then all 0, then RUN.
// - CORE_SEQ_VIRTUAL_MODE_EN undefined: the virtual_mode port is absent and ALLRST is
//   unreachable and may be removed.
// TESTING
// - mask = 4'b1011, each core passes 50 cycles after release -> run order 0, 1, 3;
//   pass_mask_o = 4'b1011; a single done_o pulse.
// - Core 1 fail and pass rise in the same cycle -> fail_mask_o[1] = 1, pass_mask_o[1] = 0.
// - timeout_limit = 100, core 0 silent -> tmo_mask_o[0] = 1 after exactly 100 RUN cycles;
//   core_reset_o[0] back to 1.
// - start with program_loaded low for 20 cycles -> tile_reset_o stays all 1 for those
//   cycles; RUN is entered 2 cycles after program_loaded rises.
// - abort in RUN, and rst in WAIT_LOAD -> IDLE next cycle with resets 0; a second start
//   during busy_o is ignored.
// - With CORE_SEQ_VIRTUAL_MODE_EN, virtual_mode = 1, RESET_CYCLES = 2, mask = 4'b0011 ->
//   tile_reset_o pulses all 1 for 2 cycles before each core runs.

Source files
------------

// File: rtl/cosim_core_sequencer.sv
// Core run sequencer: releases each core in the mask in turn, waits for its pass/fail edge or a
// timeout, and collects per-core results. Optional feature macro: CORE_SEQ_VIRTUAL_MODE_EN.
module cosim_core_sequencer #(
    parameter int NUM_CORES    = 4,
    parameter int TIMEOUT_W    = 32,
    parameter int RESET_CYCLES = 2,
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NUM_CORES-1:0] i_core_mask,
    input  logic [TIMEOUT_W-1:0] i_timeout_limit,
    input  logic                 i_program_loaded,
    input  logic [NUM_CORES-1:0] i_core_pass,
    input  logic [NUM_CORES-1:0] i_core_fail,
`ifdef CORE_SEQ_VIRTUAL_MODE_EN
    input  logic                 i_virtual_mode,
`endif
    output logic [NUM_CORES-1:0] o_tile_reset,
    output logic [NUM_CORES-1:0] o_core_reset,
    output logic [CW-1:0]        o_cur_core,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NUM_CORES-1:0] o_pass_mask,
    output logic [NUM_CORES-1:0] o_fail_mask,
    output logic [NUM_CORES-1:0] o_tmo_mask
);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOAD, S_SELECT, S_ALLRST, S_RUN, S_NEXT, S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_CORES-1:0] r_mask, w_mask_nxt;
    logic [TIMEOUT_W-1:0] r_limit, w_limit_nxt, r_cnt, w_cnt_nxt;
    logic [CW-1:0]        r_ptr, w_ptr_nxt, r_cur, w_cur_nxt;
    logic [RW-1:0]        r_rcnt, w_rcnt_nxt;
    logic [NUM_CORES-1:0] r_pass_q, r_fail_q;
    logic [NUM_CORES-1:0] r_tile, w_tile_nxt, r_core, w_core_nxt;
    logic [NUM_CORES-1:0] r_pass, w_pass_nxt, r_fail, w_fail_nxt, r_tmo, w_tmo_nxt;
    logic                 r_busy, r_done, w_done_nxt;
    logic                 w_virt, w_found, w_pass_edge, w_fail_edge, w_tmo_hit;
    logic [CW-1:0]        w_idx;

`ifdef CORE_SEQ_VIRTUAL_MODE_EN
    logic r_virt;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_virt <= 1'b0;
        else if (r_state == S_IDLE && i_start && !i_abort)
            r_virt <= i_virtual_mode;
    end
    assign w_virt = r_virt;
`else
    assign w_virt = 1'b0;
`endif

    // Lowest set mask bit at or above the scan pointer.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (r_mask[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_idx   = CW'(i);
            end
        end
    end

    assign w_pass_edge = i_core_pass[r_cur] & ~r_pass_q[r_cur];
    assign w_fail_edge = i_core_fail[r_cur] & ~r_fail_q[r_cur];
    assign w_tmo_hit   = (r_limit != '0) && (r_cnt == r_limit - TIMEOUT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_limit_nxt = r_limit;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_cur_nxt   = r_cur;
        w_rcnt_nxt  = r_rcnt;
        w_tile_nxt  = r_tile;
        w_core_nxt  = r_core;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;
        w_tmo_nxt   = r_tmo;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_mask_nxt  = i_core_mask;
                    w_limit_nxt = i_timeout_limit;
                    w_ptr_nxt   = '0;
                    w_pass_nxt  = '0;
                    w_fail_nxt  = '0;
                    w_tmo_nxt   = '0;
                    w_tile_nxt  = '1;
                    w_core_nxt  = '1;
                    w_state_nxt = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: begin
                if (i_program_loaded) begin
                    w_tile_nxt  = '0;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!w_found) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cur_nxt = w_idx;
                    if (w_virt) begin
                        w_tile_nxt  = '1;
                        w_rcnt_nxt  = RW'(RESET_CYCLES - 1);
                        w_state_nxt = S_ALLRST;
                    end else begin
                        w_core_nxt[w_idx] = 1'b0;
                        w_cnt_nxt         = '0;
                        w_state_nxt       = S_RUN;
                    end
                end
            end
            S_ALLRST: begin
                if (r_rcnt == '0) begin
                    w_tile_nxt        = '0;
                    w_core_nxt[r_cur] = 1'b0;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_RUN;
                end else begin
                    w_rcnt_nxt = r_rcnt - RW'(1);
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
                if (w_fail_edge || w_pass_edge || w_tmo_hit) begin
                    // Park the finished core; an edge beats a coincident timeout.
                    w_core_nxt[r_cur] = 1'b1;
                    w_state_nxt       = S_NEXT;
                    if (w_fail_edge) begin
                        w_fail_nxt[r_cur] = 1'b1;
                    end else if (w_pass_edge) begin
                        w_pass_nxt[r_cur] = 1'b1;
                    end else begin
                        w_tmo_nxt[r_cur]  = 1'b1;
                        w_fail_nxt[r_cur] = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                w_ptr_nxt = r_cur + CW'(1);
                if (int'(r_cur) == NUM_CORES - 1) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_SELECT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_tile_nxt  = '0;
            w_core_nxt  = '0;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = r_pass;
            w_fail_nxt  = r_fail;
            w_tmo_nxt   = r_tmo;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_limit  <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_cur    <= '0;
            r_rcnt   <= '0;
            r_pass_q <= '0;
            r_fail_q <= '0;
            r_tile   <= '0;
            r_core   <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_tmo    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_limit  <= w_limit_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cur    <= w_cur_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_pass_q <= i_core_pass;
            r_fail_q <= i_core_fail;
            r_tile   <= w_tile_nxt;
            r_core   <= w_core_nxt;
            r_pass   <= w_pass_nxt;
            r_fail   <= w_fail_nxt;
            r_tmo    <= w_tmo_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign o_tile_reset = r_tile;
    assign o_core_reset = r_core;
    assign o_cur_core   = r_cur;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass_mask  = r_pass;
    assign o_fail_mask  = r_fail;
    assign o_tmo_mask   = r_tmo;
endmodule
